// File: rtl/bit_stream_gen.sv
// Serial bit-stream source: emits a left-aligned pattern word MSB-first or a
// free-running 16-bit Fibonacci PRBS, each bit held for a programmable number of cycles.
module bit_stream_gen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        load,
  input  logic [15:0] pat,
  input  logic [4:0]  nbits,
  input  logic [1:0]  hold,
  input  logic        stop,
  output logic        out,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic [4:0]  bit_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        mode_q;
  logic [15:0] sr_q;
  logic [3:0]  rem_q;
  logic [1:0]  hold_q;
  logic [1:0]  hcnt_q;
  logic        out_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;
  logic [4:0]  cnt_q;

  logic [4:0]  len_d;
  logic [15:0] load_word_d;
  logic [15:0] sr_adv_d;
  logic [3:0]  rem_init_d;
  logic        bit_end_d;
  logic        last_bit_d;

  function automatic logic [4:0] eff_len(input logic [4:0] n);
    return (n == 5'd0 || n > 5'd16) ? 5'd16 : n;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Left-align the active field so both modes emit from bit 15 and shift left.
  function automatic logic [15:0] align_msb(input logic [15:0] p, input logic [4:0] n);
    logic [4:0] sh;
    sh = 5'd16 - n;
    return p << sh;
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] c);
    return (c == 5'd31) ? c : c + 5'd1;
  endfunction

  always_comb begin
    len_d       = eff_len(nbits);
    rem_init_d  = 4'(len_d - 5'd1);
    load_word_d = mode ? ((pat == 16'd0) ? SEED : pat) : align_msb(pat, len_d);
    sr_adv_d    = mode_q ? lfsr_step(sr_q) : {sr_q[14:0], 1'b0};
    bit_end_d   = (hcnt_q == hold_q);
    last_bit_d  = !mode_q && (rem_q == 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      sr_q    <= SEED;
      rem_q   <= 4'd0;
      hold_q  <= 2'd0;
      hcnt_q  <= 2'd0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (load && !stop) begin
            state_q <= EMIT;
            mode_q  <= mode;
            hold_q  <= hold;
            hcnt_q  <= 2'd0;
            cnt_q   <= 5'd0;
            rem_q   <= rem_init_d;
            sr_q    <= load_word_d;
            out_q   <= load_word_d[15];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        EMIT: begin
          if (stop) begin
            state_q <= IDLE;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (bit_end_d) begin
            hcnt_q <= 2'd0;
            cnt_q  <= sat_inc(cnt_q);
            if (last_bit_d) begin
              state_q <= DONE;
              out_q   <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              sr_q  <= sr_adv_d;
              out_q <= sr_adv_d[15];
              if (!mode_q) rem_q <= rem_q - 4'd1;
            end
          end else begin
            hcnt_q <= hcnt_q + 2'd1;
          end
        end
        DONE: begin
          // Load and stop are both ignored here; the block always returns to IDLE.
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          out_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out     = out_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_cnt = cnt_q;

endmodule
